// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store control stage: size encodings,
// per-entry bookkeeping layout and the load alignment/extension function.
package lsu_defs;

  localparam int LSU_XLEN = 32;

  localparam logic [1:0] LSU_SZ_B = 2'b00;
  localparam logic [1:0] LSU_SZ_H = 2'b01;
  localparam logic [1:0] LSU_SZ_W = 2'b10;

  // Everything about an outstanding access except its tag and data.
  typedef struct packed {
    logic       read;
    logic [1:0] size;
    logic       usign;
    logic [1:0] lane;
  } lsu_meta_t;

  // Size 2'b11 falls through to the word case.
  function automatic logic [LSU_XLEN-1:0] lsu_extract(
    input logic [LSU_XLEN-1:0] rdata,
    input logic [1:0]          size,
    input logic [1:0]          lane,
    input logic                usign
  );
    logic [7:0]          b;
    logic [15:0]         h;
    logic [LSU_XLEN-1:0] res;
    b = rdata[8*lane +: 8];
    h = rdata[16*lane[1] +: 16];
    case (size)
      LSU_SZ_B: res = {{(LSU_XLEN-8){b[7] & ~usign}}, b};
      LSU_SZ_H: res = {{(LSU_XLEN-16){h[15] & ~usign}}, h};
      default:  res = rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_rsp_fifo.sv
// In-order buffer of outstanding accesses; each entry is filled one cycle
// after its push and the head can be served straight from the fill data.
module lsu_rsp_fifo
  import lsu_defs::*;
#(
  parameter int DEPTH      = 2,
  parameter int ITAG_WIDTH = 1,
  parameter int XLEN       = 32,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  lsu_meta_t             push_meta,
  input  logic [ITAG_WIDTH-1:0] push_itag,
  input  logic                  pop,
  input  logic [XLEN-1:0]       fill_data,
  output logic [CW-1:0]         count,
  output logic                  head_valid,
  output lsu_meta_t             head_meta,
  output logic [ITAG_WIDTH-1:0] head_itag,
  output logic [XLEN-1:0]       head_data
);

  lsu_meta_t             meta_q [DEPTH];
  logic [ITAG_WIDTH-1:0] itag_q [DEPTH];
  logic [XLEN-1:0]       data_q [DEPTH];
  logic [DEPTH-1:0]      dvld_q;

  logic [PW-1:0] wr_ptr, rd_ptr, fill_ptr;
  logic          fill_pend;
  logic          head_fill;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill_ptr  <= '0;
      fill_pend <= 1'b0;
      count     <= '0;
      dvld_q    <= '0;
    end else begin
      count     <= count_d;
      fill_pend <= push;
      if (push) begin
        wr_ptr         <= wr_ptr + PW'(1);
        fill_ptr       <= wr_ptr;
        dvld_q[wr_ptr] <= 1'b0;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      // The fill slot is always the previous push, so it never collides with wr_ptr.
      if (fill_pend) dvld_q[fill_ptr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      meta_q[wr_ptr] <= push_meta;
      itag_q[wr_ptr] <= push_itag;
    end
    if (fill_pend && meta_q[fill_ptr].read) data_q[fill_ptr] <= fill_data;
  end

  assign head_fill  = fill_pend && (fill_ptr == rd_ptr);
  assign head_valid = (count != '0) && (dvld_q[rd_ptr] || head_fill);
  assign head_meta  = meta_q[rd_ptr];
  assign head_itag  = itag_q[rd_ptr];
  assign head_data  = head_fill ? fill_data : data_q[rd_ptr];

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: drives the DTCM on command acceptance and returns
// store completions and extended load data strictly in issue order.
module lsu_ctrl
  import lsu_defs::*;
#(
  parameter int XLEN            = 32,
  parameter int DTCM_ADDR_WIDTH = 16,
  parameter int ITAG_WIDTH      = 1,
  parameter int OUTS_DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         agu_cmd_valid,
  output logic                         agu_cmd_ready,
  input  logic [DTCM_ADDR_WIDTH-1:0]   agu_cmd_addr,
  input  logic                         agu_cmd_read,
  input  logic [ITAG_WIDTH-1:0]        agu_cmd_itag,
  input  logic [1:0]                   agu_cmd_size,
  input  logic                         agu_cmd_usign,
  input  logic [XLEN-1:0]              agu_cmd_wdata,
  input  logic [XLEN/8-1:0]            agu_cmd_wmask,
  output logic                         agu_rsp_valid,
  input  logic                         agu_rsp_ready,
  output logic                         lsu_wbck_o_valid,
  input  logic                         lsu_wbck_o_ready,
  output logic [XLEN-1:0]              lsu_wbck_o_data,
  output logic [ITAG_WIDTH-1:0]        lsu_wbck_o_itag,
  output logic                         dtcm_cs,
  output logic                         dtcm_we,
  output logic [DTCM_ADDR_WIDTH-3:0]   dtcm_addr,
  output logic [XLEN-1:0]              dtcm_wdata,
  output logic [XLEN/8-1:0]            dtcm_wmask,
  input  logic [XLEN-1:0]              dtcm_rdata
);

  localparam int CW = $clog2(OUTS_DEPTH + 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // once raised, valid and its payload hold until that transfer.
  logic          issue;
  logic          pop;
  logic [CW-1:0] count;
  logic          head_valid;
  lsu_meta_t     head_meta;
  lsu_meta_t     push_meta;
  logic [XLEN-1:0] head_data;

  assign agu_cmd_ready = (count < CW'(OUTS_DEPTH));
  assign issue         = agu_cmd_valid && agu_cmd_ready;

  assign dtcm_cs    = issue;
  assign dtcm_we    = issue && !agu_cmd_read;
  assign dtcm_addr  = agu_cmd_addr[DTCM_ADDR_WIDTH-1:2];
  assign dtcm_wdata = agu_cmd_wdata;
  assign dtcm_wmask = agu_cmd_read ? '0 : agu_cmd_wmask;

  always_comb begin
    push_meta       = '0;
    push_meta.read  = agu_cmd_read;
    push_meta.size  = agu_cmd_size;
    push_meta.usign = agu_cmd_usign;
    push_meta.lane  = agu_cmd_addr[1:0];
  end

  lsu_rsp_fifo #(
    .DEPTH      (OUTS_DEPTH),
    .ITAG_WIDTH (ITAG_WIDTH),
    .XLEN       (XLEN)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (issue),
    .push_meta  (push_meta),
    .push_itag  (agu_cmd_itag),
    .pop        (pop),
    .fill_data  (dtcm_rdata),
    .count      (count),
    .head_valid (head_valid),
    .head_meta  (head_meta),
    .head_itag  (lsu_wbck_o_itag),
    .head_data  (head_data)
  );

  assign agu_rsp_valid    = head_valid && !head_meta.read;
  assign lsu_wbck_o_valid = head_valid && head_meta.read;
  assign lsu_wbck_o_data  = lsu_extract(head_data, head_meta.size, head_meta.lane, head_meta.usign);
  assign pop = (agu_rsp_valid && agu_rsp_ready) || (lsu_wbck_o_valid && lsu_wbck_o_ready);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios plus random traffic against an
// SRAM model and an in-order expected-response queue.
module tb_lsu_ctrl;

  localparam int XLEN = 32;
  localparam int AW   = 16;
  localparam int IW   = 1;
  localparam int W    = XLEN + IW + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            agu_cmd_valid, agu_cmd_ready;
  logic [AW-1:0]   agu_cmd_addr;
  logic            agu_cmd_read;
  logic [IW-1:0]   agu_cmd_itag;
  logic [1:0]      agu_cmd_size;
  logic            agu_cmd_usign;
  logic [XLEN-1:0] agu_cmd_wdata;
  logic [3:0]      agu_cmd_wmask;
  logic            agu_rsp_valid, agu_rsp_ready;
  logic            lsu_wbck_o_valid, lsu_wbck_o_ready;
  logic [XLEN-1:0] lsu_wbck_o_data;
  logic [IW-1:0]   lsu_wbck_o_itag;
  logic            dtcm_cs, dtcm_we;
  logic [AW-3:0]   dtcm_addr;
  logic [XLEN-1:0] dtcm_wdata;
  logic [3:0]      dtcm_wmask;
  logic [XLEN-1:0] dtcm_rdata;

  logic [XLEN-1:0] mem [64];
  logic [W-1:0]    exp_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;

  lsu_ctrl #(.XLEN(XLEN), .DTCM_ADDR_WIDTH(AW), .ITAG_WIDTH(IW), .OUTS_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .agu_cmd_valid(agu_cmd_valid), .agu_cmd_ready(agu_cmd_ready),
    .agu_cmd_addr(agu_cmd_addr), .agu_cmd_read(agu_cmd_read),
    .agu_cmd_itag(agu_cmd_itag), .agu_cmd_size(agu_cmd_size),
    .agu_cmd_usign(agu_cmd_usign), .agu_cmd_wdata(agu_cmd_wdata),
    .agu_cmd_wmask(agu_cmd_wmask),
    .agu_rsp_valid(agu_rsp_valid), .agu_rsp_ready(agu_rsp_ready),
    .lsu_wbck_o_valid(lsu_wbck_o_valid), .lsu_wbck_o_ready(lsu_wbck_o_ready),
    .lsu_wbck_o_data(lsu_wbck_o_data), .lsu_wbck_o_itag(lsu_wbck_o_itag),
    .dtcm_cs(dtcm_cs), .dtcm_we(dtcm_we), .dtcm_addr(dtcm_addr),
    .dtcm_wdata(dtcm_wdata), .dtcm_wmask(dtcm_wmask), .dtcm_rdata(dtcm_rdata)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // SRAM model: read data is only meaningful the cycle after a read select.
  always @(posedge clk) begin
    if (dtcm_cs && dtcm_we) begin
      for (int i = 0; i < 4; i++)
        if (dtcm_wmask[i]) mem[dtcm_addr[5:0]][8*i +: 8] <= dtcm_wdata[8*i +: 8];
    end
    if (dtcm_cs && !dtcm_we) dtcm_rdata <= mem[dtcm_addr[5:0]];
    else                     dtcm_rdata <= $urandom;
  end

  function automatic logic [XLEN-1:0] ref_load(input logic [XLEN-1:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic usign);
    logic [XLEN-1:0] v;
    if (size == 2'd0) begin
      v = (word >> (8 * lane)) & 32'hFF;
      if (!usign && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (word >> (16 * (lane / 2))) & 32'hFFFF;
      if (!usign && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // Scoreboard: sampled on the falling edge, ahead of the edge that acts on it.
  always @(negedge clk) begin
    logic         has, issue;
    logic [W-1:0] head;
    if (rst) begin
      exp_q.delete();
    end else begin
      has  = (exp_q.size() != 0);
      head = has ? exp_q[0] : '0;
      check("cmd_ready", agu_cmd_ready, exp_q.size() < 2);
      check("rsp_valid", agu_rsp_valid, has && !head[W-1]);
      check("wbck_valid", lsu_wbck_o_valid, has && head[W-1]);
      if (has && head[W-1]) begin
        check("wbck_data", lsu_wbck_o_data, head[XLEN-1:0]);
        check("wbck_itag", lsu_wbck_o_itag, head[XLEN +: IW]);
      end
      issue = agu_cmd_valid && agu_cmd_ready;
      check("dtcm_cs", dtcm_cs, issue);
      if (issue) begin
        check("dtcm_we", dtcm_we, !agu_cmd_read);
        check("dtcm_addr", dtcm_addr, agu_cmd_addr >> 2);
        check("dtcm_wmask", dtcm_wmask, agu_cmd_read ? 4'h0 : agu_cmd_wmask);
        if (!agu_cmd_read) check("dtcm_wdata", dtcm_wdata, agu_cmd_wdata);
      end
      if (has && ((agu_rsp_valid && agu_rsp_ready) || (lsu_wbck_o_valid && lsu_wbck_o_ready)))
        void'(exp_q.pop_front());
      if (issue)
        exp_q.push_back({agu_cmd_read, agu_cmd_itag,
                         agu_cmd_read ? ref_load(mem[agu_cmd_addr[7:2]], agu_cmd_size,
                                                 agu_cmd_addr[1:0], agu_cmd_usign)
                                      : {XLEN{1'b0}}});
    end
  end

  // Driver: present one command and hold it until accepted.
  task automatic send(input logic rd, input logic [AW-1:0] addr, input logic [1:0] size,
                      input logic usign, input logic [IW-1:0] itag,
                      input logic [XLEN-1:0] wdata, input logic [3:0] wmask);
    logic done;
    done          = 1'b0;
    agu_cmd_valid = 1'b1;
    agu_cmd_read  = rd;
    agu_cmd_addr  = addr;
    agu_cmd_size  = size;
    agu_cmd_usign = usign;
    agu_cmd_itag  = itag;
    agu_cmd_wdata = wdata;
    agu_cmd_wmask = wmask;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = agu_cmd_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("cmd_timeout", 1'b0, 1'b1);
    agu_cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    rst = 1'b1;
    agu_cmd_valid = 1'b0; agu_cmd_addr = '0; agu_cmd_read = 1'b0; agu_cmd_itag = '0;
    agu_cmd_size = 2'b10; agu_cmd_usign = 1'b0; agu_cmd_wdata = '0; agu_cmd_wmask = '0;
    agu_rsp_ready = 1'b1; lsu_wbck_o_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Word store, then byte and half loads with known memory contents
    send(1'b0, 16'h0010, 2'b10, 1'b0, 1'b0, 32'hDEADBEEF, 4'hF);
    idle(2);
    mem[4] = 32'h80FF_1234;
    send(1'b1, 16'h0013, 2'b00, 1'b0, 1'b1, '0, 4'h0);
    send(1'b1, 16'h0013, 2'b00, 1'b1, 1'b1, '0, 4'h0);
    idle(2);
    mem[4] = 32'h8001_0000;
    send(1'b1, 16'h0012, 2'b01, 1'b0, 1'b0, '0, 4'h0);
    send(1'b1, 16'h0012, 2'b01, 1'b1, 1'b1, '0, 4'h0);
    idle(2);

    // Three loads into a stalled write-back port
    lsu_wbck_o_ready = 1'b0;
    fork
      begin
        send(1'b1, 16'h0010, 2'b10, 1'b0, 1'b0, '0, 4'h0);
        send(1'b1, 16'h0015, 2'b00, 1'b0, 1'b1, '0, 4'h0);
        send(1'b1, 16'h001A, 2'b01, 1'b1, 1'b0, '0, 4'h0);
      end
      begin
        idle(5);
        lsu_wbck_o_ready = 1'b1;
        idle(1);
        lsu_wbck_o_ready = 1'b0;
      end
    join
    idle(3);
    lsu_wbck_o_ready = 1'b1;
    idle(3);

    // Stalled store completion holds back a following load
    agu_rsp_ready = 1'b0;
    send(1'b0, 16'h0020, 2'b10, 1'b0, 1'b0, 32'h1357_9BDF, 4'b0110);
    send(1'b1, 16'h0021, 2'b00, 1'b0, 1'b1, '0, 4'h0);
    idle(3);
    agu_rsp_ready = 1'b1;
    idle(3);

    // Reset with two loads outstanding
    lsu_wbck_o_ready = 1'b0;
    send(1'b1, 16'h0030, 2'b10, 1'b0, 1'b0, '0, 4'h0);
    send(1'b1, 16'h0034, 2'b10, 1'b0, 1'b1, '0, 4'h0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    lsu_wbck_o_ready = 1'b1;
    idle(4);

    // Random traffic
    repeat (500) begin
      agu_cmd_valid    = ($urandom_range(0, 3) != 0);
      agu_cmd_read     = $urandom_range(0, 1);
      agu_cmd_addr     = 16'($urandom_range(0, 255));
      agu_cmd_size     = 2'($urandom_range(0, 3));
      agu_cmd_usign    = $urandom_range(0, 1);
      agu_cmd_itag     = IW'($urandom_range(0, 1));
      agu_cmd_wdata    = $urandom;
      agu_cmd_wmask    = 4'($urandom_range(0, 15));
      agu_rsp_ready    = ($urandom_range(0, 3) != 0);
      lsu_wbck_o_ready = ($urandom_range(0, 3) != 0);
      idle(1);
    end
    agu_cmd_valid = 1'b0;
    agu_rsp_ready = 1'b1;
    lsu_wbck_o_ready = 1'b1;
    idle(10);
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
